// File: rtl/axi_log_event_arbiter.sv
// -----------------------------------------------------------------------------
// axi_log_event_arbiter
//
// Merges AR and AW address-channel handshakes of a monitored AXI port into a
// single event stream for one BRAM logger. Each channel buffers its captured
// handshakes in a small FIFO. A one-entry output register presents the events
// to the logger with a valid/ready handshake. The output register is granted
// round-robin between the two FIFOs. A saturating counter records the events
// lost to a full FIFO or a full logger.
//
// Ports
//   Clk_CI, Rst_RBI             clock, asynchronous active-low reset
//   Ar*_SI/_DI, Aw*_SI/_DI      monitored AR/AW handshake and payload
//   Enable_SI                   capture enable
//   Clear_SI                    synchronous flush of FIFOs, output and counters
//   LogFull_SI                  logger full: new events are dropped
//   LogReady_SI                 logger accepts the presented event
//   LogValid_SO, LogIsWr_SO     event valid, 1 = AW event / 0 = AR event
//   LogId_DO/LogAddr_DO/LogLen_DO  event payload
//   DropCnt_DO, Overflow_SO     saturating drop count, sticky drop flag
// -----------------------------------------------------------------------------
module axi_log_event_arbiter #(
    parameter int unsigned AXI_ADDR_BITW = 32,
    parameter int unsigned AXI_ID_BITW   = 8,
    parameter int unsigned AXI_LEN_BITW  = 8,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned DROP_CNT_BITW = 16
) (
    input  logic                     Clk_CI,
    input  logic                     Rst_RBI,
    input  logic                     ArValid_SI,
    input  logic                     ArReady_SI,
    input  logic [AXI_ID_BITW-1:0]   ArId_DI,
    input  logic [AXI_ADDR_BITW-1:0] ArAddr_DI,
    input  logic [AXI_LEN_BITW-1:0]  ArLen_DI,
    input  logic                     AwValid_SI,
    input  logic                     AwReady_SI,
    input  logic [AXI_ID_BITW-1:0]   AwId_DI,
    input  logic [AXI_ADDR_BITW-1:0] AwAddr_DI,
    input  logic [AXI_LEN_BITW-1:0]  AwLen_DI,
    input  logic                     Enable_SI,
    input  logic                     Clear_SI,
    input  logic                     LogFull_SI,
    input  logic                     LogReady_SI,
    output logic                     LogValid_SO,
    output logic                     LogIsWr_SO,
    output logic [AXI_ID_BITW-1:0]   LogId_DO,
    output logic [AXI_ADDR_BITW-1:0] LogAddr_DO,
    output logic [AXI_LEN_BITW-1:0]  LogLen_DO,
    output logic [DROP_CNT_BITW-1:0] DropCnt_DO,
    output logic                     Overflow_SO
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = AXI_ID_BITW + AXI_ADDR_BITW + AXI_LEN_BITW;

    typedef logic [ENTRY_W-1:0] entry_t;

    // Channel index 0 = AR, 1 = AW throughout.
    entry_t             mem_q   [2][FIFO_DEPTH];
    logic [PTR_W-1:0]   wptr_q  [2];
    logic [PTR_W-1:0]   rptr_q  [2];
    logic [CNT_W-1:0]   cnt_q   [2];

    logic               valid_q;
    logic               is_wr_q;
    entry_t             data_q;
    logic [DROP_CNT_BITW-1:0] drop_cnt_q;
    logic               ovf_q;
    logic               prio_wr_q;  // channel preferred when both FIFOs hold data

    logic [1:0]         ev;
    logic [1:0]         full;
    logic [1:0]         non_empty;
    logic [1:0]         push;
    logic [1:0]         drop;
    logic [1:0]         pop;
    logic [1:0]         drop_inc;
    entry_t             entry_in [2];
    logic               load;
    logic               grant_wr;
    logic               any_ne;

    function automatic logic [DROP_CNT_BITW-1:0] sat_add(
        input logic [DROP_CNT_BITW-1:0] a,
        input logic [1:0]               inc
    );
        logic [DROP_CNT_BITW:0] sum;
        sum = {1'b0, a} + (DROP_CNT_BITW+1)'(inc);
        return sum[DROP_CNT_BITW] ? '1 : sum[DROP_CNT_BITW-1:0];
    endfunction

    always_comb begin
        ev[0]       = ArValid_SI & ArReady_SI & Enable_SI & ~Clear_SI;
        ev[1]       = AwValid_SI & AwReady_SI & Enable_SI & ~Clear_SI;
        entry_in[0] = {ArId_DI, ArAddr_DI, ArLen_DI};
        entry_in[1] = {AwId_DI, AwAddr_DI, AwLen_DI};
        for (int c = 0; c < 2; c++) begin
            // Fullness uses the registered count: a pop in the same cycle
            // does not make room for a push.
            full[c]      = (cnt_q[c] == CNT_W'(FIFO_DEPTH));
            non_empty[c] = (cnt_q[c] != '0);
            push[c]      = ev[c] & ~full[c] & ~LogFull_SI;
            drop[c]      = ev[c] & (full[c] | LogFull_SI);
        end
        drop_inc = {1'b0, drop[0]} + {1'b0, drop[1]};

        load     = ~valid_q | LogReady_SI;
        any_ne   = non_empty[0] | non_empty[1];
        grant_wr = (non_empty[0] & non_empty[1]) ? prio_wr_q : non_empty[1];
        pop[0]   = load & non_empty[0] & ~grant_wr;
        pop[1]   = load & non_empty[1] &  grant_wr;
    end

    // FIFO storage carries data only; occupancy is tracked by the counters.
    always_ff @(posedge Clk_CI) begin
        for (int c = 0; c < 2; c++) begin
            if (push[c]) begin
                mem_q[c][wptr_q[c]] <= entry_in[c];
            end
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            for (int c = 0; c < 2; c++) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
            valid_q    <= 1'b0;
            is_wr_q    <= 1'b0;
            data_q     <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
            prio_wr_q  <= 1'b0;
        end else if (Clear_SI) begin
            for (int c = 0; c < 2; c++) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
            valid_q    <= 1'b0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
            prio_wr_q  <= 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (push[c]) wptr_q[c] <= wptr_q[c] + 1'b1;
                if (pop[c])  rptr_q[c] <= rptr_q[c] + 1'b1;
                cnt_q[c] <= cnt_q[c] + CNT_W'(push[c]) - CNT_W'(pop[c]);
            end
            if (load) begin
                valid_q <= any_ne;
            end
            if (load && any_ne) begin
                data_q    <= mem_q[grant_wr][rptr_q[grant_wr]];
                is_wr_q   <= grant_wr;
                prio_wr_q <= ~grant_wr;
            end
            drop_cnt_q <= sat_add(drop_cnt_q, drop_inc);
            ovf_q      <= ovf_q | (|drop);
        end
    end

    assign LogValid_SO = valid_q;
    assign LogIsWr_SO  = is_wr_q;
    assign LogId_DO    = data_q[ENTRY_W-1 -: AXI_ID_BITW];
    assign LogAddr_DO  = data_q[AXI_LEN_BITW +: AXI_ADDR_BITW];
    assign LogLen_DO   = data_q[AXI_LEN_BITW-1:0];
    assign DropCnt_DO  = drop_cnt_q;
    assign Overflow_SO = ovf_q;

endmodule
